// File: rtl/core_inst_seq_if.sv
// core_inst_seq_if: bundles the row-fetch request, the core-facing
// instruction/data bus and the start/busy/done handshake of one sequencer.
//   start     : launch request into the sequencer
//   data_sel  : row source select (0 = Q, 1 = K)
//   data_idx  : row index requested from the row source
//   data_in   : requested row, combinational in data_sel/data_idx
//   mem_in    : data bus to the core
//   inst      : 17-bit core instruction word
//   busy      : sequence in progress
//   done      : one-cycle end-of-sequence pulse
// master = sequencer side, slave = core / row source / controller side.
interface core_inst_seq_if #(
    parameter int bw = 4,
    parameter int pr = 8
);
    logic                 start;
    logic                 data_sel;
    logic [3:0]           data_idx;
    logic [pr*bw-1:0]     data_in;
    logic [pr*bw-1:0]     mem_in;
    logic [16:0]          inst;
    logic                 busy;
    logic                 done;

    modport master (
        input  start,
        input  data_in,
        output data_sel,
        output data_idx,
        output mem_in,
        output inst,
        output busy,
        output done
    );

    modport slave (
        output start,
        output data_in,
        input  data_sel,
        input  data_idx,
        input  mem_in,
        input  inst,
        input  busy,
        input  done
    );
endinterface

// File: rtl/core_inst_seq.sv
// core_inst_seq: drives one fullchip core through a full Q*K^T pass
// (Q write, K write, K load, execute, OFIFO-to-PMEM move) from a single
// start pulse. Every output is registered.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : core_inst_seq_if master modport (start, row fetch, mem_in,
//           inst, busy, done)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; Q[0] already requested
// QWR    | write Q rows 0..total_cycle-1 into qmem
// SP1    | one spacer cycle, K[0] requested
// KWR    | write K rows 0..col-1 into kmem
// SP2    | one spacer cycle
// KLOAD  | load asserted col+2 cycles, kmem read in the middle col
// GAP1   | gap idle cycles
// EXEC   | execute + qmem read, total_cycle cycles
// GAP2   | gap idle cycles
// MOVE   | ofifo read + pmem write, total_cycle cycles
// GAP3   | gap idle cycles
// DONE   | done pulse, still busy
module core_inst_seq #(
    parameter int bw          = 4,
    parameter int pr          = 8,
    parameter int col         = 8,
    parameter int total_cycle = 8,
    parameter int gap         = 10
) (
    input  logic            clk,
    input  logic            reset,
    core_inst_seq_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_QWR, S_SP1, S_KWR, S_SP2, S_KLOAD,
        S_GAP1, S_EXEC, S_GAP2, S_MOVE, S_GAP3, S_DONE
    } state_t;

    // Counter must hold the longest phase and still expose a 4-bit address.
    localparam int M1 = (col + 2 > 16) ? col + 2 : 16;
    localparam int M2 = (gap > M1) ? gap : M1;
    localparam int M3 = (total_cycle > M2) ? total_cycle : M2;
    localparam int CW = $clog2(M3 + 1);

    localparam logic [CW-1:0] QLAST  = CW'(total_cycle - 1);
    localparam logic [CW-1:0] KLAST  = CW'(col - 1);
    localparam logic [CW-1:0] LDLAST = CW'(col + 1);
    localparam logic [CW-1:0] KRDMAX = CW'(col);
    localparam logic [CW-1:0] GLAST  = CW'(gap - 1);

    state_t             state, nxt_state;
    logic [CW-1:0]      cnt, nxt_cnt;

    logic [16:0]        inst_q, nxt_inst;
    logic [pr*bw-1:0]   mem_in_q;
    logic               sel_q, nxt_sel;
    logic [3:0]         idx_q, nxt_idx;
    logic               busy_q, nxt_busy;
    logic               done_q, nxt_done;
    logic               load_row;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            inst_q   <= '0;
            mem_in_q <= '0;
            sel_q    <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            inst_q   <= nxt_inst;
            mem_in_q <= load_row ? bus.data_in : '0;
            sel_q    <= nxt_sel;
            idx_q    <= nxt_idx;
            busy_q   <= nxt_busy;
            done_q   <= nxt_done;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + CW'(1);
        case (state)
            S_IDLE:  begin
                nxt_cnt = '0;
                if (bus.start) nxt_state = S_QWR;
            end
            S_QWR:   if (cnt == QLAST)  nxt_state = S_SP1;
            S_SP1:   nxt_state = S_KWR;
            S_KWR:   if (cnt == KLAST)  nxt_state = S_SP2;
            S_SP2:   nxt_state = S_KLOAD;
            S_KLOAD: if (cnt == LDLAST) nxt_state = S_GAP1;
            S_GAP1:  if (cnt == GLAST)  nxt_state = S_EXEC;
            S_EXEC:  if (cnt == QLAST)  nxt_state = S_GAP2;
            S_GAP2:  if (cnt == GLAST)  nxt_state = S_MOVE;
            S_MOVE:  if (cnt == QLAST)  nxt_state = S_GAP3;
            S_GAP3:  if (cnt == GLAST)  nxt_state = S_DONE;
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
        if (nxt_state != state) nxt_cnt = '0;
    end

    // Outputs are decoded from the upcoming state/count so they land in the
    // register on the same edge as the state. The row request looks one
    // further cycle ahead, so data_in is settled when mem_in captures it.
    always_comb begin
        nxt_inst = '0;
        nxt_sel  = 1'b0;
        nxt_idx  = '0;
        nxt_done = 1'b0;
        nxt_busy = (nxt_state != S_IDLE);
        load_row = 1'b0;
        case (nxt_state)
            S_QWR: begin
                nxt_inst[4]     = 1'b1;
                nxt_inst[15:12] = nxt_cnt[3:0];
                load_row        = 1'b1;
                if (nxt_cnt != QLAST) nxt_idx = nxt_cnt[3:0] + 4'd1;
            end
            S_SP1: nxt_sel = 1'b1;
            S_KWR: begin
                nxt_inst[2]     = 1'b1;
                nxt_inst[15:12] = nxt_cnt[3:0];
                load_row        = 1'b1;
                nxt_sel         = 1'b1;
                if (nxt_cnt != KLAST) nxt_idx = nxt_cnt[3:0] + 4'd1;
            end
            S_KLOAD: begin
                nxt_inst[6] = 1'b1;
                if (nxt_cnt != '0 && nxt_cnt <= KRDMAX) begin
                    nxt_inst[3]     = 1'b1;
                    // 4-bit wrap is exact here: cnt=16 maps to address 15.
                    nxt_inst[15:12] = nxt_cnt[3:0] - 4'd1;
                end
            end
            S_EXEC: begin
                nxt_inst[7]     = 1'b1;
                nxt_inst[5]     = 1'b1;
                nxt_inst[15:12] = nxt_cnt[3:0];
            end
            S_MOVE: begin
                nxt_inst[16]   = 1'b1;
                nxt_inst[0]    = 1'b1;
                nxt_inst[11:8] = nxt_cnt[3:0];
            end
            S_DONE: nxt_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.inst     = inst_q;
    assign bus.mem_in   = mem_in_q;
    assign bus.data_sel = sel_q;
    assign bus.data_idx = idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: directed bench for core_inst_seq. dut_a uses default
// parameters, dut_b the col=16/total_cycle=16/gap=1 corner. Both read a
// combinational ROM: Q row r = {8{r}}, K row r = {8{~r}} (4-bit r).
module tb_core_inst_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_inst_seq_if #(.bw(4), .pr(8)) bus_a ();
    core_inst_seq_if #(.bw(4), .pr(8)) bus_b ();

    core_inst_seq #(.bw(4), .pr(8), .col(8), .total_cycle(8), .gap(10)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    core_inst_seq #(.bw(4), .pr(8), .col(16), .total_cycle(16), .gap(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    assign bus_a.data_in = bus_a.data_sel ? {8{~bus_a.data_idx}} : {8{bus_a.data_idx}};
    assign bus_b.data_in = bus_b.data_sel ? {8{~bus_b.data_idx}} : {8{bus_b.data_idx}};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic goto_cyc(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic launch_a();
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        cyc = 1;
    endtask

    task automatic launch_b();
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (bus_a.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus_a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout busy=%b required=0", bus_a.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_a.inst !== 17'h0) begin n_fail++; $display("FAIL rst_inst got=%h exp=0", bus_a.inst); end
        n_checks++;
        if (bus_a.mem_in !== 32'h0) begin n_fail++; $display("FAIL rst_mem_in got=%h exp=0", bus_a.mem_in); end
        n_checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy_done got=%b%b exp=00", bus_a.busy, bus_a.done);
        end
        n_checks++;
        if (bus_a.data_sel !== 1'b0 || bus_a.data_idx !== 4'h0) begin
            n_fail++; $display("FAIL rst_req got=%b/%h exp=0/0", bus_a.data_sel, bus_a.data_idx);
        end
        n_checks++;
        if (bus_b.inst !== 17'h0 || bus_b.busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_b got=%h/%b exp=0/0", bus_b.inst, bus_b.busy);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start busy=%b exp=0", bus_a.busy); end
    endtask

    task automatic test_qwr_kwr();
        logic [16:0] exp_i;
        logic [31:0] exp_m;
        logic [3:0]  a4;
        launch_a();
        for (int a = 0; a < 8; a++) begin
            goto_cyc(1 + a);
            a4 = 4'(a);
            exp_i = 17'h00010 | (17'(a) << 12);
            exp_m = {8{a4}};
            n_checks++;
            if (bus_a.inst !== exp_i || bus_a.mem_in !== exp_m) begin
                n_fail++;
                $display("FAIL qwr a=%0d got=%h/%h exp=%h/%h", a, bus_a.inst, bus_a.mem_in, exp_i, exp_m);
            end
        end
        goto_cyc(9);
        n_checks++;
        if (bus_a.inst !== 17'h0 || bus_a.mem_in !== 32'h0) begin
            n_fail++; $display("FAIL sp1 got=%h/%h exp=0/0", bus_a.inst, bus_a.mem_in);
        end
        for (int a = 0; a < 8; a++) begin
            goto_cyc(10 + a);
            a4 = 4'(a);
            exp_i = 17'h00004 | (17'(a) << 12);
            exp_m = {8{~a4}};
            n_checks++;
            if (bus_a.inst !== exp_i || bus_a.mem_in !== exp_m) begin
                n_fail++;
                $display("FAIL kwr a=%0d got=%h/%h exp=%h/%h", a, bus_a.inst, bus_a.mem_in, exp_i, exp_m);
            end
        end
        wait_idle_a();
    endtask

    task automatic test_kload();
        logic [16:0] exp_i;
        launch_a();
        goto_cyc(18);
        n_checks++;
        if (bus_a.inst !== 17'h0) begin n_fail++; $display("FAIL sp2 got=%h exp=0", bus_a.inst); end
        for (int i = 0; i < 10; i++) begin
            goto_cyc(19 + i);
            exp_i = 17'h00040;
            if (i >= 1 && i <= 8) exp_i = exp_i | 17'h00008 | (17'(i - 1) << 12);
            n_checks++;
            if (bus_a.inst !== exp_i || bus_a.mem_in !== 32'h0) begin
                n_fail++;
                $display("FAIL kload i=%0d got=%h/%h exp=%h/0", i, bus_a.inst, bus_a.mem_in, exp_i);
            end
        end
        goto_cyc(29);
        n_checks++;
        if (bus_a.inst !== 17'h0) begin n_fail++; $display("FAIL gap1 got=%h exp=0", bus_a.inst); end
        wait_idle_a();
    endtask

    task automatic test_exec_move();
        logic [16:0] exp_i;
        launch_a();
        goto_cyc(38);
        n_checks++;
        if (bus_a.inst !== 17'h0) begin n_fail++; $display("FAIL pre_exec got=%h exp=0", bus_a.inst); end
        for (int a = 0; a < 8; a++) begin
            goto_cyc(39 + a);
            exp_i = 17'h000A0 | (17'(a) << 12);
            n_checks++;
            if (bus_a.inst !== exp_i) begin
                n_fail++; $display("FAIL exec a=%0d got=%h exp=%h", a, bus_a.inst, exp_i);
            end
        end
        for (int k = 47; k <= 56; k++) begin
            goto_cyc(k);
            n_checks++;
            if (bus_a.inst !== 17'h0) begin n_fail++; $display("FAIL gap2 cyc=%0d got=%h exp=0", k, bus_a.inst); end
        end
        for (int a = 0; a < 8; a++) begin
            goto_cyc(57 + a);
            exp_i = 17'h10001 | (17'(a) << 8);
            n_checks++;
            if (bus_a.inst !== exp_i) begin
                n_fail++; $display("FAIL move a=%0d got=%h exp=%h", a, bus_a.inst, exp_i);
            end
        end
        goto_cyc(65);
        n_checks++;
        if (bus_a.inst !== 17'h0) begin n_fail++; $display("FAIL gap3 got=%h exp=0", bus_a.inst); end
        wait_idle_a();
    endtask

    task automatic test_completion();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        launch_a();
        for (int k = 1; k <= 76; k++) begin
            goto_cyc(k);
            if (bus_a.busy === 1'b1) busy_cnt++;
            if (bus_a.done === 1'b1) begin
                done_cnt++;
                done_cyc = k;
            end
            bus_a.start = (k % 6 == 3 && k < 70) ? 1'b1 : 1'b0;
        end
        bus_a.start = 1'b0;
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 75) begin
            n_fail++; $display("FAIL done_pulse count=%0d cyc=%0d exp=1/75", done_cnt, done_cyc);
        end
        n_checks++;
        if (busy_cnt !== 75) begin n_fail++; $display("FAIL busy_len got=%0d exp=75", busy_cnt); end
        goto_cyc(80);
        n_checks++;
        if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL no_restart busy=%b exp=0", bus_a.busy); end
    endtask

    task automatic test_back_to_back();
        launch_a();
        goto_cyc(74);
        bus_a.start = 1'b1;
        goto_cyc(75);
        n_checks++;
        if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done got=%b/%b exp=1/1", bus_a.done, bus_a.busy);
        end
        goto_cyc(76);
        n_checks++;
        if (bus_a.busy !== 1'b0 || bus_a.inst !== 17'h0) begin
            n_fail++; $display("FAIL b2b_idle got=%b/%h exp=0/0", bus_a.busy, bus_a.inst);
        end
        goto_cyc(77);
        bus_a.start = 1'b0;
        n_checks++;
        if (bus_a.busy !== 1'b1 || bus_a.inst !== 17'h00010 || bus_a.mem_in !== 32'h0) begin
            n_fail++; $display("FAIL b2b_relaunch got=%b/%h/%h exp=1/00010/0", bus_a.busy, bus_a.inst, bus_a.mem_in);
        end
        goto_cyc(78);
        n_checks++;
        if (bus_a.inst !== 17'h01010 || bus_a.mem_in !== 32'h11111111) begin
            n_fail++; $display("FAIL b2b_q1 got=%h/%h exp=01010/11111111", bus_a.inst, bus_a.mem_in);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid();
        launch_a();
        goto_cyc(4);
        n_checks++;
        if (bus_a.inst !== 17'h03010) begin n_fail++; $display("FAIL mid_qwr got=%h exp=03010", bus_a.inst); end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (bus_a.inst !== 17'h0 || bus_a.mem_in !== 32'h0 || bus_a.busy !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_qwr got=%h/%h/%b exp=0/0/0", bus_a.inst, bus_a.mem_in, bus_a.busy);
        end
        @(negedge clk);
        reset = 1'b1;
        launch_a();
        goto_cyc(42);
        n_checks++;
        if (bus_a.inst !== 17'h030A0) begin n_fail++; $display("FAIL mid_exec got=%h exp=030A0", bus_a.inst); end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (bus_a.inst !== 17'h0 || bus_a.busy !== 1'b0 || bus_a.data_idx !== 4'h0) begin
            n_fail++; $display("FAIL async_rst_exec got=%h/%b/%h exp=0/0/0", bus_a.inst, bus_a.busy, bus_a.data_idx);
        end
        @(negedge clk);
        reset = 1'b1;
        launch_a();
        n_checks++;
        if (bus_a.inst !== 17'h00010 || bus_a.mem_in !== 32'h0) begin
            n_fail++; $display("FAIL restart_q0 got=%h/%h exp=00010/0", bus_a.inst, bus_a.mem_in);
        end
        goto_cyc(2);
        n_checks++;
        if (bus_a.inst !== 17'h01010 || bus_a.mem_in !== 32'h11111111) begin
            n_fail++; $display("FAIL restart_q1 got=%h/%h exp=01010/11111111", bus_a.inst, bus_a.mem_in);
        end
        wait_idle_a();
    endtask

    task automatic test_corner();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        logic [16:0] exp_i;
        logic [31:0] exp_m;
        launch_b();
        for (int k = 1; k <= 89; k++) begin
            goto_cyc(k);
            if (bus_b.busy === 1'b1) busy_cnt++;
            if (bus_b.done === 1'b1) begin
                done_cnt++;
                done_cyc = k;
            end
            exp_m = 32'h0;
            case (k)
                1:  exp_i = 17'h00010;
                16: begin exp_i = 17'h0F010; exp_m = 32'hFFFFFFFF; end
                17: exp_i = 17'h00000;
                18: begin exp_i = 17'h00004; exp_m = 32'hFFFFFFFF; end
                33: exp_i = 17'h0F004;
                35: exp_i = 17'h00040;
                51: exp_i = 17'h0F048;
                52: exp_i = 17'h00040;
                53: exp_i = 17'h00000;
                54: exp_i = 17'h000A0;
                69: exp_i = 17'h0F0A0;
                70: exp_i = 17'h00000;
                71: exp_i = 17'h10001;
                86: exp_i = 17'h10F01;
                87: exp_i = 17'h00000;
                default: exp_i = 17'h1FFFF;
            endcase
            if (exp_i != 17'h1FFFF) begin
                n_checks++;
                if (bus_b.inst !== exp_i || bus_b.mem_in !== exp_m) begin
                    n_fail++;
                    $display("FAIL corner cyc=%0d got=%h/%h exp=%h/%h", k, bus_b.inst, bus_b.mem_in, exp_i, exp_m);
                end
            end
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 88) begin
            n_fail++; $display("FAIL corner_done count=%0d cyc=%0d exp=1/88", done_cnt, done_cyc);
        end
        n_checks++;
        if (busy_cnt !== 88) begin n_fail++; $display("FAIL corner_busy_len got=%0d exp=88", busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_qwr_kwr();
        test_kload();
        test_exec_move();
        test_completion();
        test_back_to_back();
        test_reset_mid();
        test_corner();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
